lsearch_ctrl: RTL and testbench

- Bus initiator that performs a linear search over a word array held in data memory.
- Drives the memory's MemRead/MemWrite/addr/write_data inputs and consumes its combinational read_data.
- Accepts a start command with key, base byte address and element count; reports found flag and element index with a one-cycle done pulse.
- Sits between the top-level control/testbench and the data memory. It is the master side of the memory interface.

---
 rtl/lsearch_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lsearch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsearch_ctrl.sv
// lsearch_ctrl: bus initiator that linearly scans a word array in data memory
// for a key and reports the lowest matching element index.
//
// One element is compared per cycle against the memory's combinational read
// data. A start in IDLE latches key, base (word aligned) and element count; the
// result (found, index) is published with a one-cycle done pulse and held until
// the next accepted start. abort cancels a scan without a done pulse.
//
// Optional feature: define LSEARCH_WRITEBACK_EN to add port wb_addr and a WB
// state that writes {found, 0..., index} to wb_addr for one cycle before DONE.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          command strobe (IDLE only), scan cancel (SCAN only)
//   key, base_addr, count search key, byte address of element 0, element count
//   wb_addr               result write-back byte address (feature only)
//   mem_read, mem_write   memory MemRead / MemWrite
//   mem_addr, mem_wdata   memory byte address / write data
//   mem_rdata             memory read data, valid in the same cycle as mem_addr
//   busy, done            not-IDLE flag, one-cycle completion pulse
//   found, index          search result
module lsearch_ctrl #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   key,
  input  logic [31:0]   base_addr,
  input  logic [AW:0]   count,
`ifdef LSEARCH_WRITEBACK_EN
  input  logic [31:0]   wb_addr,
`endif
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] index
);

  localparam logic [AW:0] IdxOne = 1;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
`ifdef LSEARCH_WRITEBACK_EN
    ,
    StWb
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [AW:0]    idx_q, idx_d;
  logic [AW:0]    idx_inc;
  logic [31:0]    key_q, key_d;
  logic [29:0]    base_q, base_d;
  logic [AW:0]    count_q, count_d;
  logic           found_q, found_d;
  logic [AW-1:0]  index_q, index_d;
  logic           mem_read_q, mem_read_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic           finish;
`ifdef LSEARCH_WRITEBACK_EN
  logic [29:0]    wb_q, wb_d;
  logic           mem_write_q, mem_write_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic [3:0]     unused_low_bits;
  assign unused_low_bits = {base_addr[1:0], wb_addr[1:0]};
`else
  logic [1:0]     unused_low_bits;
  assign unused_low_bits = base_addr[1:0];
`endif

  assign idx_inc = idx_q + IdxOne;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    key_d      = key_q;
    base_d     = base_q;
    count_d    = count_q;
    found_d    = found_q;
    index_d    = index_q;
    // Memory strobes are asserted only for the cycle they are computed for.
    mem_read_d = 1'b0;
    mem_addr_d = '0;
    finish     = 1'b0;
`ifdef LSEARCH_WRITEBACK_EN
    wb_d        = wb_q;
    mem_write_d = 1'b0;
    mem_wdata_d = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = key;
          base_d  = base_addr[31:2];
          count_d = count;
          found_d = 1'b0;
          index_d = '0;
          idx_d   = '0;
`ifdef LSEARCH_WRITEBACK_EN
          wb_d    = wb_addr[31:2];
`endif
          if (count == '0) begin
            finish = 1'b1;
          end else begin
            state_d    = StScan;
            mem_read_d = 1'b1;
            mem_addr_d = {base_addr[31:2], 2'b00};
          end
        end
      end
      StScan: begin
        if (abort) begin
          state_d = StIdle;
          found_d = 1'b0;
          index_d = '0;
        end else if (mem_rdata == key_q) begin
          found_d = 1'b1;
          index_d = idx_q[AW-1:0];
          finish  = 1'b1;
        end else if (idx_q == count_q - IdxOne) begin
          found_d = 1'b0;
          index_d = '0;
          finish  = 1'b1;
        end else begin
          idx_d      = idx_inc;
          mem_read_d = 1'b1;
          // Word address wraps modulo 2^30.
          mem_addr_d = {base_q + 30'(idx_inc), 2'b00};
        end
      end
`ifdef LSEARCH_WRITEBACK_EN
      StWb: begin
        state_d = StDone;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (finish) begin
`ifdef LSEARCH_WRITEBACK_EN
      state_d     = StWb;
      mem_write_d = 1'b1;
      mem_addr_d  = {wb_d, 2'b00};
      mem_wdata_d = {found_d, {(31 - AW){1'b0}}, index_d};
`else
      state_d = StDone;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      key_q      <= '0;
      base_q     <= '0;
      count_q    <= '0;
      found_q    <= 1'b0;
      index_q    <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
`ifdef LSEARCH_WRITEBACK_EN
      wb_q        <= '0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      key_q      <= key_d;
      base_q     <= base_d;
      count_q    <= count_d;
      found_q    <= found_d;
      index_q    <= index_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
`ifdef LSEARCH_WRITEBACK_EN
      wb_q        <= wb_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
`endif
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign found    = found_q;
  assign index    = index_q;
  assign mem_read = mem_read_q;
  assign mem_addr = mem_addr_q;
`ifdef LSEARCH_WRITEBACK_EN
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;
`else
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
`endif

endmodule

// File: tb/tb_lsearch_ctrl.sv
// Self-checking bench for lsearch_ctrl. A word-array memory model answers the
// DUT combinationally; each search's expected result, latency and address
// sequence come from a plain linear-search reference over that array.
module tb_lsearch_ctrl;
  localparam int unsigned AW = 10;
  localparam int Words = 1 << AW;
`ifdef LSEARCH_WRITEBACK_EN
  localparam int WbExtra = 1;
`else
  localparam int WbExtra = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   key = '0;
  logic [31:0]   base_addr = '0;
  logic [AW:0]   count = '0;
`ifdef LSEARCH_WRITEBACK_EN
  logic [31:0]   wb_addr = '0;
`endif
  logic          mem_read, mem_write, busy, done, found;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [AW-1:0] index;

  logic [31:0] mem [Words];
  assign mem_rdata = mem[mem_addr[AW+1:2]];

  int n_cmp = 0;
  int n_err = 0;

  lsearch_ctrl #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .key       (key),
    .base_addr (base_addr),
    .count     (count),
`ifdef LSEARCH_WRITEBACK_EN
    .wb_addr   (wb_addr),
`endif
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .index     (index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a search at the current negedge (cycle 0) and follows it to done.
  task automatic search(input logic [31:0] k, input logic [31:0] b, input int n,
                        input bit noise, input bit abort0);
    bit          ef;
    int          ei;
    int          reads;
    int          lat;
    int          done_c;
    bit          saw_wr;
    logic [29:0] w;
    logic [31:0] wb;
    ef = 1'b0;
    ei = 0;
    for (int j = 0; j < n; j++) begin
      if (mem[(b[31:2] + j) % Words] === k) begin
        ef = 1'b1;
        ei = j;
        break;
      end
    end
    reads = ef ? ei + 1 : n;
    lat   = reads + 1 + WbExtra;
    wb    = $urandom;
    key       = k;
    base_addr = b;
    count     = (AW + 1)'(n);
    start     = 1'b1;
    abort     = abort0;
`ifdef LSEARCH_WRITEBACK_EN
    wb_addr   = wb;
`endif
    done_c = -1;
    saw_wr = 1'b0;
    for (int c = 1; c <= lat + 3; c++) begin
      @(negedge clk);
      abort = 1'b0;
      check("mem_read", mem_read, c <= reads);
      if (mem_read) begin
        w = b[31:2] + 30'(c - 1);
        check("scan_addr", mem_addr, {w, 2'b00});
      end
      if (mem_write) begin
        saw_wr = 1'b1;
        check("wb_cycle", c, reads + 1);
        check("wb_addr", mem_addr, {wb[31:2], 2'b00});
        check("wb_data", mem_wdata, (32'(ef) << 31) | 32'(ei));
      end else begin
        check("wdata_idle", mem_wdata, 0);
      end
      if (done) begin
        done_c = c;
        break;
      end
      if (noise) begin
        start     = 1'($urandom);
        key       = $urandom_range(0, 9);
        base_addr = $urandom;
        count     = (AW + 1)'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", done_c, lat);
    check("write_seen", saw_wr, WbExtra);
    check("found", found, ef);
    check("index", index, ei);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("found_hold", found, ef);
    check("index_hold", index, ei);
    check("idle_bus", {mem_read, mem_addr}, 0);
  endtask

  task automatic fill_directed();
    for (int i = 0; i < Words; i++) mem[i] = 32'h1000 + i;
    for (int i = 0; i < 5; i++) mem[i] = i;
  endtask

  initial begin
    fill_directed();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {found, index}, 0);
    check("rst_bus", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic hit, miss, empty, start-while-busy, simultaneous start+abort.
    search(32'd3, 32'h0, 5, 1'b0, 1'b0);
    search(32'd7, 32'h0, 5, 1'b0, 1'b0);
    mem[2] = 32'hA5;
    mem[4] = 32'hA5;
    search(32'hA5, 32'h0, 5, 1'b0, 1'b0);
    search(32'hA5, 32'h0, 0, 1'b0, 1'b0);
    fill_directed();
    search(32'd3, 32'h0, 5, 1'b1, 1'b0);
    search(32'd4, 32'h3, 5, 1'b0, 1'b1);

    // Abort during cycle 2 of a 5-element scan.
    search(32'd3, 32'h0, 5, 1'b0, 1'b0);
    key = 32'd7; base_addr = 32'h0; count = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_nodone1", done, 0);
    @(negedge clk);
    check("abort_nodone2", done, 0);
    check("abort_busy2", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy3", busy, 0);
    check("abort_done3", done, 0);
    check("abort_result", {found, index}, 0);
    check("abort_read", mem_read, 0);
    search(32'd2, 32'h0, 5, 1'b0, 1'b0);

    // Asynchronous reset mid-scan.
    key = 32'd7; base_addr = 32'h0; count = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_bus", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
    check("arst_result", {done, found, index}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word-address wrap past the top of the 30-bit space.
    mem[Words - 1] = 32'h55;
    search(32'h55, 32'hFFFF_FFFA, 4, 1'b0, 1'b0);
    search(32'h77, 32'hFFFF_FFF8, 4, 1'b0, 1'b0);

    // Maximum count: miss, then hit on the last element.
    for (int i = 0; i < Words; i++) mem[i] = $urandom_range(0, 7);
    search(32'd100, 32'h0000_0804, Words, 1'b0, 1'b0);
    mem[(32'h201 + Words - 1) % Words] = 32'd100;
    search(32'd100, 32'h0000_0804, Words, 1'b0, 1'b0);

    // Randomised searches.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < Words; i++) mem[i] = $urandom_range(0, 7);
      search($urandom_range(0, 9), $urandom, $urandom_range(0, 40), 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
